// File: rtl/mem_rd_pkg.sv
// Shared types for the activation-memory row reader.
package mem_rd_pkg;

    localparam int WORD_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_HOLD,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/mem_row_reader.sv
// Fetches row_count consecutive rows from a 1-cycle-latency 64-bit memory and
// presents each reassembled row over a valid/ready handshake.
module mem_row_reader
    import mem_rd_pkg::*;
#(
    parameter int ROW_BYTES = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [15:0]            row_count,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_write_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [63:0]            mem_data_in,
    output logic                   row_valid,
    input  logic                   row_ready,
    output logic [ROW_BYTES*8-1:0] row_data,
    output logic [15:0]            row_idx
);

    localparam int WORDS  = ROW_BYTES / WORD_BYTES;
    localparam int SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [SLOT_W-1:0] LAST_WORD = SLOT_W'(WORDS - 1);

    rd_state_e              r_state;
    logic [ADDR_W-1:0]      r_cur_addr;
    logic [ADDR_W-1:0]      r_last_addr;
    logic [15:0]            r_rows_left;
    logic [SLOT_W-1:0]      r_word_cnt;
    logic                   r_pend;
    logic [SLOT_W-1:0]      r_slot;
    logic [ROW_BYTES*8-1:0] r_row_data;
    logic                   r_row_valid;
    logic [15:0]            r_row_idx;
    logic                   r_done;
    logic [63:0]            w_word;

    // Memory words are big-endian: the top byte is the lowest row byte.
    always_comb begin
        w_word = '0;
        for (int j = 0; j < WORD_BYTES; j++)
            w_word[8*j +: 8] = mem_data_in[63-8*j -: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_addr  <= '0;
            r_last_addr <= '0;
            r_rows_left <= '0;
            r_word_cnt  <= '0;
            r_pend      <= 1'b0;
            r_slot      <= '0;
            r_row_data  <= '0;
            r_row_valid <= 1'b0;
            r_row_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_pend <= 1'b0;
            if (r_pend)
                r_row_data[int'(r_slot)*64 +: 64] <= w_word;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (row_count != 16'd0) begin
                            r_cur_addr  <= base_addr;
                            r_rows_left <= row_count;
                            r_row_idx   <= '0;
                            r_word_cnt  <= '0;
                            r_state     <= ST_FETCH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_FETCH: begin
                    // Read data returns next cycle, so the slot rides along with pend.
                    r_last_addr <= r_cur_addr;
                    r_cur_addr  <= r_cur_addr + 1'b1;
                    r_pend      <= 1'b1;
                    r_slot      <= r_word_cnt;
                    r_word_cnt  <= r_word_cnt + 1'b1;
                    if (r_word_cnt == LAST_WORD)
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_row_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (row_ready) begin
                        r_row_valid <= 1'b0;
                        r_rows_left <= r_rows_left - 1'b1;
                        if (r_rows_left == 16'd1) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_row_idx  <= r_row_idx + 1'b1;
                            r_word_cnt <= '0;
                            r_state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr     = (r_state == ST_FETCH) ? r_cur_addr : r_last_addr;
    assign mem_write_en = 1'b0;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign row_valid    = r_row_valid;
    assign row_data     = r_row_data;
    assign row_idx      = r_row_idx;

endmodule

// File: tb/tb_mem_row_reader.sv
// Directed bench for mem_row_reader with a row scoreboard and a behavioural memory.
module tb_mem_row_reader;

    localparam int ROW_BYTES = 32;
    localparam int ADDR_W    = 32;
    localparam int WORDS     = ROW_BYTES / 8;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [ADDR_W-1:0]      base_addr = '0;
    logic [15:0]            row_count = '0;
    logic                   busy, done, mem_write_en, row_valid;
    logic [ADDR_W-1:0]      mem_addr;
    logic [63:0]            mem_data_in;
    logic                   row_ready = 1'b0;
    logic [ROW_BYTES*8-1:0] row_data;
    logic [15:0]            row_idx;

    mem_row_reader #(.ROW_BYTES(ROW_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .row_count(row_count), .busy(busy), .done(done),
        .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .row_valid(row_valid),
        .row_ready(row_ready), .row_data(row_data), .row_idx(row_idx)
    );

    always #5 clk = ~clk;

    // Byte b of word a holds (8a+b) mod 256, byte 0 in the top lane.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        logic [31:0] v;
        w = '0;
        for (int b = 0; b < 8; b++) begin
            v = a * 32'd8 + 32'(b);
            w[63-8*b -: 8] = v[7:0];
        end
        return w;
    endfunction

    always @(posedge clk) mem_data_in <= mem_word(mem_addr);

    function automatic logic [ROW_BYTES*8-1:0] exp_row(input logic [31:0] base, input int r);
        logic [ROW_BYTES*8-1:0] e;
        logic [31:0] v;
        e = '0;
        for (int k = 0; k < ROW_BYTES; k++) begin
            v = (base + 32'(r * WORDS)) * 32'd8 + 32'(k);
            e[8*k +: 8] = v[7:0];
        end
        return e;
    endfunction

    logic [ROW_BYTES*8-1:0] q_data[$];
    logic [15:0]            q_idx[$];
    logic [31:0]            addr_log[$];
    logic [31:0]            prev_addr = '0;
    int n_pass = 0, n_chk = 0, n_fail = 0, n_done = 0;
    bit we_bad = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] base, input int cnt);
        for (int r = 0; r < cnt; r++) begin
            q_data.push_back(exp_row(base, r));
            q_idx.push_back(16'(r));
        end
    endtask

    // Handshake is judged on the values that will be seen at the coming edge.
    task automatic step();
        logic                   hs;
        logic [ROW_BYTES*8-1:0] d;
        logic [15:0]            ix;
        hs = row_valid && row_ready;
        d  = row_data;
        ix = row_idx;
        @(negedge clk);
        if (hs) begin
            if (q_data.size() == 0) chk("sb_unexpected_row", 1, 0);
            else begin
                chk("sb_row_data", d, q_data.pop_front());
                chk("sb_row_idx", ix, q_idx.pop_front());
            end
        end
        if (mem_write_en !== 1'b0) we_bad = 1'b1;
        if (busy && mem_addr !== prev_addr) addr_log.push_back(mem_addr);
        prev_addr = mem_addr;
        if (done) n_done++;
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [15:0] cnt);
        base_addr = base;
        row_count = cnt;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (n_done == 0 && i < 200) begin
            step();
            i++;
        end
        chk(tag, n_done, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, row_valid, 0);
        chk({tag, "_we"}, mem_write_en, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_data"}, row_data, 0);
        chk({tag, "_idx"}, row_idx, 0);
    endtask

    initial begin
        logic [ROW_BYTES*8-1:0] snap;
        bit stable;
        int logsz;

        // Reset and idle
        repeat (3) step();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        repeat (2) step();
        chk_reset_vals("idle");

        // Single row from address 0, exact cycle timing
        row_ready = 1'b1;
        push_cmd(0, 1);
        base_addr = 0; row_count = 1; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            start = 1'b0;
            chk($sformatf("t1_addr_c%0d", c + 1), mem_addr, c);
            chk($sformatf("t1_busy_c%0d", c + 1), busy, 1);
        end
        step();
        chk("t1_addr_hold_c5", mem_addr, 3);
        chk("t1_valid_c5", row_valid, 0);
        step();
        chk("t1_valid_c6", row_valid, 1);
        chk("t1_idx_c6", row_idx, 0);
        chk("t1_data_c6", row_data, exp_row(0, 0));
        step();
        chk("t1_done_c7", done, 1);
        chk("t1_busy_c7", busy, 1);
        step();
        chk("t1_done_c8", done, 0);
        chk("t1_busy_c8", busy, 0);
        chk("t1_sb_empty", q_data.size(), 0);

        // Three rows from address 8
        n_done = 0;
        addr_log.delete();
        push_cmd(8, 3);
        pulse_start(8, 3);
        wait_done("t2_done");
        repeat (3) step();
        chk("t2_one_done", n_done, 1);
        chk("t2_idle", busy, 0);
        chk("t2_sb_empty", q_data.size(), 0);
        chk("t2_addr_cnt", addr_log.size(), 12);
        for (int i = 0; i < 12 && i < addr_log.size(); i++)
            chk($sformatf("t2_addr_%0d", i), addr_log[i], 8 + i);

        // Backpressure in HOLD
        n_done = 0;
        addr_log.delete();
        row_ready = 1'b0;
        push_cmd(100, 2);
        pulse_start(100, 2);
        for (int i = 0; i < 20 && !row_valid; i++) step();
        chk("t3_valid", row_valid, 1);
        chk("t3_data", row_data, exp_row(100, 0));
        snap = row_data;
        logsz = addr_log.size();
        stable = 1'b1;
        repeat (10) begin
            step();
            if (row_data !== snap || row_valid !== 1'b1) stable = 1'b0;
        end
        chk("t3_stable", stable, 1);
        chk("t3_no_new_addr", addr_log.size(), logsz);
        row_ready = 1'b1;
        wait_done("t3_done");
        step();
        chk("t3_sb_empty", q_data.size(), 0);
        chk("t3_addr_cnt", addr_log.size(), 8);

        // Zero-row command
        n_done = 0;
        addr_log.delete();
        pulse_start(55, 0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        step();
        chk("t4_done_off", done, 0);
        chk("t4_busy_off", busy, 0);
        chk("t4_no_reads", addr_log.size(), 0);

        // Start during FETCH is ignored
        n_done = 0;
        push_cmd(200, 1);
        pulse_start(200, 1);
        base_addr = 500; row_count = 5; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t4b_done");
        repeat (3) step();
        chk("t4b_one_done", n_done, 1);
        chk("t4b_idle", busy, 0);
        chk("t4b_sb_empty", q_data.size(), 0);
        chk("t4b_addr_cnt", addr_log.size(), 4);
        if (addr_log.size() > 0) chk("t4b_last_addr", addr_log[addr_log.size()-1], 203);

        // Reset during FETCH of row 1
        n_done = 0;
        push_cmd(300, 1);
        pulse_start(300, 3);
        repeat (7) step();
        chk("t5_row1_idx", row_idx, 1);
        chk("t5_row1_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk_reset_vals("t5_rst");
        step();
        chk("t5_no_done", n_done, 0);
        chk("t5_sb_empty", q_data.size(), 0);
        rst_n = 1'b1;
        step();
        addr_log.delete();
        push_cmd(40, 1);
        pulse_start(40, 1);
        wait_done("t5_restart_done");
        step();
        chk("t5_sb_empty2", q_data.size(), 0);
        chk("t5_addr_cnt", addr_log.size(), 4);
        if (addr_log.size() > 0) chk("t5_first_addr", addr_log[0], 40);

        chk("we_never_high", we_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_row_reader.md
# mem_row_reader

Read-side initiator for the 64-bit synchronous-read activation memory. On a `start` command it fetches `row_count` consecutive rows of `ROW_BYTES` int8 values starting at `base_addr`, one 64-bit word per cycle. It reassembles each row into a flat byte vector and presents it downstream (to the MHSA compute array) over a valid/ready handshake. The memory has a fixed 1-cycle read latency and no read enable; this block only ever reads.

## Interface
- `ROW_BYTES`, 32: bytes per row; must be a multiple of 8. `WORDS = ROW_BYTES/8`, default 4.
- `ADDR_W`, 32: memory address width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: 1-cycle command pulse; sampled only in IDLE.
- `base_addr` in ADDR_W: word address of row 0; latched on accepted `start`.
- `row_count` in 16: number of rows; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: 1-cycle pulse when the command completes.
- `mem_write_en` out 1: constant 0.
- `mem_addr` out ADDR_W: word read address.
- `mem_data_in` in 64: memory read data, valid the cycle after its address is presented.
- `row_valid` out 1: `row_data` holds a complete row.
- `row_ready` in 1: downstream accepts the row.
- `row_data` out ROW_BYTES*8: row byte k at bits [8k+7:8k].
- `row_idx` out 16: index (0-based) of the row currently presented.

## Operation
- States: IDLE, FETCH, DRAIN, HOLD, DONE.
- **IDLE**
  - `start` with `row_count != 0`: latch `cur_addr = base_addr` and `rows_left = row_count`; clear `row_idx` and `word_cnt`; go to FETCH.
  - `start` with `row_count == 0`: go to DONE; no memory access.
- **FETCH**
  - Each cycle: `mem_addr = cur_addr`, then increment `cur_addr` and `word_cnt`.
  - After issuing word `WORDS-1`: go to DRAIN.
- **Capture** (runs in parallel with the FSM)
  - A registered pending flag and slot index track each read; when pending, the returned word is written into its row slot.
  - Word w lands in row bytes 8w..8w+7. `mem_data_in[63:56]` is byte 8w and `mem_data_in[7:0]` is byte 8w+7 (big-endian within the word).
- **DRAIN**: captures the last word; go to HOLD.
- **HOLD**
  - `row_valid = 1`; `row_data` and `row_idx` are stable until the handshake.
  - On `row_valid && row_ready`: decrement `rows_left`.
  - Rows remain: increment `row_idx`, clear `word_cnt`, go to FETCH in the next cycle. `cur_addr` continues contiguously.
  - Otherwise: go to DONE.
- **DONE**: `done = 1` for exactly one cycle; go to IDLE.
- `start` outside IDLE is ignored.
- `cur_addr` wraps modulo 2^ADDR_W. No range check against memory depth.
- `row_ready` is ignored while `row_valid = 0`.

## Timing
- Reset values: IDLE; `busy`, `done`, `row_valid`, `mem_write_en` = 0; `mem_addr`, `row_data`, `row_idx` = 0.
- Take the edge that samples `start` as E0:
  - addresses issued in cycles 1..WORDS;
  - data captured at edges E2..E(WORDS+1);
  - `row_valid` rises after E(WORDS+1), i.e. 5 cycles for the default configuration.
- Per-row cost with `row_ready` held high: WORDS+2 cycles (FETCH×WORDS, DRAIN, HOLD).
- `mem_addr` holds its last value outside FETCH.
- `done` is asserted in the cycle after the final handshake; `busy` drops the cycle after `done`.
- Reset asserted mid-command: immediate return to reset values. Any in-flight read data is discarded, and no `done` is produced.

## Structure
- Package `mem_rd_pkg`: state enum `rd_state_e` and constant `WORD_BYTES = 8`.
- Single module; no sub-module. Unpack and capture are a simple slot write.

## Test plan
Memory model preloaded so that byte b of word a = (8a+b) mod 256.
- Reset then idle: all outputs 0, `mem_write_en` = 0 throughout.
- `start`, `base_addr` = 0, `row_count` = 1, `row_ready` = 1 -> `mem_addr` 0,1,2,3 in cycles 1-4; `row_valid` in cycle 6 (rises after E5) with byte k = k and `row_idx` = 0; `done` pulse one cycle later.
- `base_addr` = 8, `row_count` = 3, `row_ready` = 1 -> rows start at bytes 64, 96, 128; `row_idx` 0,1,2; `mem_addr` 8..19 contiguous; exactly one `done`.
- Backpressure: `row_ready` low for 10 cycles in HOLD -> `row_data` stable, no new `mem_addr`; completes normally once `row_ready` rises.
- `row_count` = 0 -> no reads, `done` one cycle after `start`. A `start` pulse in FETCH is ignored.
- `rst_n` low during FETCH of row 1 -> all outputs return to reset values; a new `start` then runs cleanly from the new `base_addr`.
